// File: rtl/bitstream_pkg.sv
// ============================================================================
// bitstream_pkg : shared types and LFSR tap table for stochastic sources
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } gen_state_t;

  localparam int DEFAULT_SEED = 'hA5;

  // Right-shift Galois toggle masks of primitive polynomials, widths 4..16.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h0009;
      5:       return 16'h0012;
      6:       return 16'h0021;
      7:       return 16'h0041;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_galois.sv
// ============================================================================
// lfsr_galois : maximal-length Galois LFSR with seed load and advance enable
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module lfsr_galois
  import bitstream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] q
);

  localparam logic [15:0]      c_taps_all = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] c_taps     = c_taps_all[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_seed_raw = WIDTH'(SEED);
  // An all-zero state would lock the register, so it is replaced by 1.
  localparam logic [WIDTH-1:0] c_seed     = (c_seed_raw == '0) ? WIDTH'(1) : c_seed_raw;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = c_seed;
    end else if (advance) begin
      q_d = (q_q >> 1) ^ ({WIDTH{q_q[0]}} & c_taps);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_q <= c_seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/bitstream_generator.sv
// ============================================================================
// bitstream_generator : binary value to framed unipolar stochastic bitstream
// Option macro BITSTREAM_SEED_RELOAD_EN reloads the LFSR seed on every start.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module bitstream_generator
  import bitstream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 255,
  parameter int SEED   = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  output logic             ready,
  output logic             x,
  output logic             capture,
  output logic             done
);

  localparam int            CW     = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] c_last = CW'(LENGTH - 1);

  gen_state_t       state_q;
  logic [WIDTH-1:0] value_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             capture_q;
  logic             done_q;
  logic [WIDTH-1:0] lfsr_q;
  logic             accept;
  logic             lfsr_load;

  assign accept = (state_q == IDLE) && start;

`ifdef BITSTREAM_SEED_RELOAD_EN
  assign lfsr_load = accept;
`else
  assign lfsr_load = 1'b0;
`endif

  lfsr_galois #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (lfsr_load),
    .advance (state_q == STREAM),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      capture_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            value_q   <= value;
            state_q   <= PRIME;
            ready_q   <= 1'b0;
            capture_q <= 1'b1;
          end
        end
        PRIME: begin
          state_q <= STREAM;
          cnt_q   <= '0;
        end
        STREAM: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_last) begin
            state_q   <= DONE;
            capture_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Stream bit is decoded from registered state and LFSR only.
  assign x       = (state_q == STREAM) && (lfsr_q <= value_q);
  assign ready   = ready_q;
  assign capture = capture_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bitstream_generator.sv
// ============================================================================
// tb_bitstream_generator : table, random and sequence checks with a stream model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bitstream_generator;

  localparam int L0 = 255;
  localparam int L1 = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] value0, value1;
  logic       start0, start1;
  logic       ready0, x0, capture0, done0;
  logic       ready1, x1, capture1, done1;

  int checks = 0;
  int errors = 0;

  logic [7:0] m0, m1;
  logic       g1[L1];
  logic       s1a[L1];
  logic       e1a[L1];
  logic       e1b[L1];

  always #5 clk = ~clk;

  bitstream_generator #(.WIDTH(8), .LENGTH(L0)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .value(value0), .start(start0),
    .ready(ready0), .x(x0), .capture(capture0), .done(done0)
  );

  bitstream_generator #(.WIDTH(8), .LENGTH(L1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .value(value1), .start(start1),
    .ready(ready1), .x(x1), .capture(capture1), .done(done1)
  );

  typedef struct {
    logic [7:0] v;
    bit         noise;
    int         ones;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // One framed stream on the LENGTH=255 instance, checked cycle by cycle.
  task automatic run0(input logic [7:0] v, input bit noise, input int exp_ones, input string tag);
    bit exp_bits[$];
    int ones;
    int cap;
    bit first;
    chk({tag, "_ready_pre"}, int'(ready0), 1);
`ifdef BITSTREAM_SEED_RELOAD_EN
    m0 = 8'hA5;
`endif
    for (int i = 0; i < L0; i++) begin
      exp_bits.push_back(m0 <= v);
      m0 = step(m0);
    end
    value0 = v;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ones = 0; cap = 0; first = 1'b1;
    for (int k = 1; k <= L0 + 3; k++) begin
      if (capture0) begin
        cap++;
        if (first) first = 1'b0;
        else ones += int'(x0);
      end
      if (k == 1) begin
        chk({tag, "_prime_cap"}, int'(capture0), 1);
        chk({tag, "_prime_x"}, int'(x0), 0);
        chk({tag, "_prime_ready"}, int'(ready0), 0);
      end else if (k <= L0 + 1) begin
        chk({tag, "_x"}, int'(x0), int'(exp_bits[k-2]));
        chk({tag, "_cap"}, int'(capture0), 1);
        chk({tag, "_done_early"}, int'(done0), 0);
      end else if (k == L0 + 2) begin
        chk({tag, "_done"}, int'(done0), 1);
        chk({tag, "_cap_end"}, int'(capture0), 0);
      end else begin
        chk({tag, "_ready_post"}, int'(ready0), 1);
        chk({tag, "_done_pulse"}, int'(done0), 0);
      end
      if (noise) begin
        value0 = 8'($urandom);
        start0 = (k == 40);
      end
      if (k < L0 + 3) @(negedge clk);
    end
    start0 = 1'b0;
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_cap_len"}, cap, L0 + 1);
  endtask

  // One stream on the LENGTH=64 instance; bits recorded into g1.
  task automatic run1(input logic [7:0] v, input string tag);
`ifdef BITSTREAM_SEED_RELOAD_EN
    m1 = 8'hA5;
`endif
    value1 = v;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk({tag, "_prime_cap"}, int'(capture1), 1);
    for (int k = 0; k < L1; k++) begin
      @(negedge clk);
      g1[k] = x1;
      chk({tag, "_x"}, int'(x1), int'(m1 <= v));
      m1 = step(m1);
    end
    @(negedge clk);
    chk({tag, "_done"}, int'(done1), 1);
    @(negedge clk);
    chk({tag, "_ready"}, int'(ready1), 1);
  endtask

  initial begin
    vec_t tbl[8];
    int   vals[3];
    int   wi, gap, ones;
    bit   in_win, same, exp_same;

    tbl[0] = '{8'd0,   1'b0, 0};
    tbl[1] = '{8'd255, 1'b0, 255};
    tbl[2] = '{8'd100, 1'b0, 100};
    tbl[3] = '{8'd1,   1'b0, 1};
    tbl[4] = '{8'd128, 1'b0, 128};
    tbl[5] = '{8'd254, 1'b0, 254};
    tbl[6] = '{8'd77,  1'b0, 77};
    tbl[7] = '{8'd150, 1'b1, 150};

    n_rst = 1'b0; value0 = '0; value1 = '0; start0 = 1'b0; start1 = 1'b0;
    m0 = 8'hA5; m1 = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready0), 1);
    chk("rst_x", int'(x0), 0);
    chk("rst_cap", int'(capture0), 0);
    chk("rst_done", int'(done0), 0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", int'(ready0), 1);

    for (int i = 0; i < 8; i++) run0(tbl[i].v, tbl[i].noise, tbl[i].ones, $sformatf("tbl%0d", i));

    for (int i = 0; i < 4; i++) begin
      logic [7:0] rv;
      rv = 8'($urandom_range(0, 255));
      run0(rv, 1'b0, int'(rv), $sformatf("rnd%0d", i));
    end

    // Reset at data bit 40 of a stream.
    value0 = 8'd200; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (41) @(negedge clk);
    chk("mid_cap_pre", int'(capture0), 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_cap", int'(capture0), 0);
    chk("mid_rst_x", int'(x0), 0);
    chk("mid_rst_done", int'(done0), 0);
    chk("mid_rst_ready", int'(ready0), 1);
    @(negedge clk);
    n_rst = 1'b1;
    m0 = 8'hA5; m1 = 8'hA5;
    @(negedge clk);
    run0(8'd200, 1'b0, 200, "after_rst");

    // Start held high across three streams.
    vals[0] = 10; vals[1] = 200; vals[2] = 33;
    wi = 0; gap = 0; ones = 0; in_win = 1'b0;
    value0 = 8'(vals[0]); start0 = 1'b1;
    for (int c = 0; c < 1200 && wi < 3; c++) begin
      @(negedge clk);
      if (capture0) begin
        if (!in_win) begin
          in_win = 1'b1;
          ones = 0;
          if (wi > 0) chk("b2b_gap", gap, 2);
        end else begin
          ones += int'(x0);
        end
      end else begin
        if (in_win) begin
          in_win = 1'b0;
          gap = 0;
          chk("b2b_count", ones, vals[wi]);
        end
        gap++;
      end
      if (done0) begin
        wi++;
        if (wi < 3) value0 = 8'(vals[wi]);
        else start0 = 1'b0;
      end
    end
    chk("b2b_streams", wi, 3);
    @(negedge clk);
    chk("b2b_ready", int'(ready0), 1);

    // Two identical requests on the short stream; model decides equality.
    for (int k = 0; k < L1; k++) e1a[k] = 1'b0;
    begin
      logic [7:0] s;
      s = m1;
`ifdef BITSTREAM_SEED_RELOAD_EN
      s = 8'hA5;
`endif
      for (int k = 0; k < L1; k++) begin e1a[k] = (s <= 8'd77); s = step(s); end
`ifdef BITSTREAM_SEED_RELOAD_EN
      s = 8'hA5;
`endif
      for (int k = 0; k < L1; k++) begin e1b[k] = (s <= 8'd77); s = step(s); end
    end
    exp_same = 1'b1;
    for (int k = 0; k < L1; k++) if (e1a[k] != e1b[k]) exp_same = 1'b0;
    run1(8'd77, "s1a");
    for (int k = 0; k < L1; k++) s1a[k] = g1[k];
    run1(8'd77, "s1b");
    same = 1'b1;
    for (int k = 0; k < L1; k++) if (s1a[k] != g1[k]) same = 1'b0;
    chk("s1_identical", int'(same), int'(exp_same));
`ifdef BITSTREAM_SEED_RELOAD_EN
    chk("s1_reload_same", int'(same), 1);
`else
    chk("s1_continue_differs", int'(same), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitstream_generator.md
# bitstream_generator

Converts a WIDTH-bit unsigned binary value into a unipolar stochastic bitstream of fixed length, and frames it with a `capture` window for the downstream integrator. Each stream bit compares an internal maximal-length LFSR against the latched value. The block sits at the network input: it converts binary operands into bitstreams, the bitstream arithmetic operates on them, and the integrator converts the result back to binary.

## Interface
- `WIDTH`, 8: operand and LFSR width. Legal range 4..16.
- `LENGTH`, 255: stream length in data bits, ≥1. 2**WIDTH-1 gives one full LFSR period.
- `SEED`, 'hA5: LFSR initial state. A value of 0 is replaced by 1.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `value`  in  WIDTH  unsigned operand. Sampled only when a start is accepted.
- `start`  in  1  request to begin a stream.
- `ready`  out  1  idle; can accept `start`.
- `x`  out  1  stream bit.
- `capture`  out  1  stream window for the downstream integrator.
- `done`  out  1  one-cycle pulse after the stream ends.

## Operation
- States: IDLE, PRIME, STREAM, DONE.
- **IDLE**
  - `ready`=1.
  - `start`=1 latches `value` and goes to PRIME.
- **PRIME**, one cycle
  - `capture`=1, `x`=0.
  - Exists because the integrator spends its first `capture` cycle clearing, so no bit is counted in that cycle.
  - Goes to STREAM with the bit counter at 0.
- **STREAM**
  - `capture`=1.
  - `x` = (lfsr <= value_q), unsigned compare.
  - The LFSR advances once per STREAM cycle and holds in all other states.
  - The counter (width $clog2(LENGTH+1)) increments each cycle.
  - After LENGTH STREAM cycles, goes to DONE.
- **DONE**, one cycle
  - `capture`=0, `done`=1.
  - Goes to IDLE.
- LFSR: Galois, maximal-length, taps by WIDTH. It never reaches 0, so its states are 1..2**WIDTH-1.
  - `value`=0 gives an all-zero stream.
  - `value`=2**WIDTH-1 gives an all-one stream.
  - With LENGTH=2**WIDTH-1, the number of ones equals `value` exactly, regardless of start phase.
- `start` outside IDLE is ignored, with no queueing.
- `value` changes after acceptance are ignored.
- Reset at any point:
  - state returns to IDLE;
  - LFSR returns to SEED, value_q and the counter to 0;
  - the outputs take their reset values.

## Timing
- Reset values: `ready`=1, `x`=0, `capture`=0, `done`=0.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- `start` accepted at edge T:
  - PRIME in cycle T+1;
  - data bits in T+2 .. T+1+LENGTH;
  - `done` in T+2+LENGTH;
  - `ready` again in T+3+LENGTH.
- Total `capture` high time is LENGTH+1 cycles. The downstream integrator counts exactly LENGTH bits.
- Back-to-back operation: holding `start` high gives a 2-cycle `capture`-low gap (DONE, IDLE). That gap covers the integrator's show and output cycles.

## Configuration
- `BITSTREAM_SEED_RELOAD_EN`
  - Defined: the LFSR reloads SEED on every accepted start. Every stream for a given `value` is bit-identical.
  - Undefined: the LFSR continues from where the previous stream left it. It is reset only by `n_rst`, which decorrelates successive streams.

## Structure
- Package `bitstream_pkg`:
  - `gen_state_t` enum: IDLE, PRIME, STREAM, DONE.
  - function `lfsr_taps(width)`, returning the maximal-length tap masks for widths 4..16.
  - constant `DEFAULT_SEED`.
- Sub-module `lfsr_galois` (params WIDTH, SEED; ports clk, n_rst, load, advance, q). Also reused by other stochastic sources.

## Test plan
- Reset mid-stream at data bit 40: `capture`, `x`, `done` go to 0 immediately and `ready`=1. A new start then produces a full LENGTH+1 `capture` window.
- WIDTH=8, LENGTH=255, `value`=100, then integrator capture: integrator `y`=100, `done` in cycle T+257, `capture` high for exactly 256 cycles.
- `value`=0 then 255 (LENGTH=255): `x` is always 0, then always 1 in STREAM. The integrator reads 0, then 255.
- `start` held high for three streams: `capture` gaps are exactly 2 cycles. The integrator outputs 3 correct counts.
- With `BITSTREAM_SEED_RELOAD_EN`, `value`=77 with LENGTH=64, twice: identical `x` sequences. Without the macro, the sequences differ.
- `start` pulsed during STREAM and `value` changed mid-stream: no effect on timing or on the count.
